// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One operation at a time: radix-2 shift-add multiply or restoring divide,
// XLEN iteration cycles each. Divide-by-zero and signed overflow skip the
// iterations and finish one cycle after accept. flush aborts silently.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    // hi/lo: product halves while multiplying, remainder/quotient while dividing
    logic [XLEN-1:0] hi_reg, hi_next, lo_reg, lo_next;
    // multiplicand magnitude or divisor
    logic [XLEN-1:0] opnd_reg, opnd_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic [1:0]      op_reg, op_next;
    logic            neg_reg, neg_next, rneg_reg, rneg_next;

    // accept-time decode
    logic            accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] mag_a, mag_b, min_neg, fast_res;

    assign min_neg  = {1'b1, {(XLEN-1){1'b0}}};
    assign accept   = (state_reg == IDLE) & start & ~flush;
    assign is_div   = funct3[2];
    assign a_signed = (funct3[1:0] != 2'b11) & ~(is_div & funct3[0]);
    assign b_signed = is_div ? ~funct3[0] : ~funct3[1];
    assign a_neg    = a_signed & op_a[XLEN-1];
    assign b_neg    = b_signed & op_b[XLEN-1];
    assign mag_a    = a_neg ? -op_a : op_a;
    assign mag_b    = b_neg ? -op_b : op_b;
    assign div_zero = (op_b == '0);
    assign div_ovf  = ~funct3[0] & (op_a == min_neg) & (&op_b);
    assign fast     = is_div & (div_zero | div_ovf);
    assign fast_res = div_zero ? (funct3[1] ? op_a : '1)
                               : (funct3[1] ? '0 : min_neg);

    // one iteration step and the sign-corrected final result
    logic [XLEN:0]     add_sum, shifted, diff;
    logic [XLEN-1:0]   iter_hi, iter_lo, fin_res, quo_fin, rem_fin;
    logic [2*XLEN-1:0] prod, prod_fin;

    // datapath: shift-add step, restoring-divide step, final result select
    always_comb begin
        add_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        shifted  = {hi_reg, lo_reg[XLEN-1]};
        diff     = shifted - {1'b0, opnd_reg};
        iter_hi  = hi_reg;
        iter_lo  = lo_reg;
        if (state_reg == MUL) begin
            iter_hi = add_sum[XLEN:1];
            iter_lo = {add_sum[0], lo_reg[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            iter_hi = diff[XLEN-1:0];
            iter_lo = {lo_reg[XLEN-2:0], 1'b1};
        end else begin
            iter_hi = shifted[XLEN-1:0];
            iter_lo = {lo_reg[XLEN-2:0], 1'b0};
        end
        prod     = {iter_hi, iter_lo};
        prod_fin = neg_reg ? -prod : prod;
        quo_fin  = neg_reg ? -iter_lo : iter_lo;
        rem_fin  = rneg_reg ? -iter_hi : iter_hi;
        if (state_reg == MUL)
            fin_res = (op_reg == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
        else
            fin_res = op_reg[1] ? rem_fin : quo_fin;
    end

    // next-state and register-update logic; flush overrides everything
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        opnd_next   = opnd_reg;
        result_next = result_reg;
        op_next     = op_reg;
        neg_next    = neg_reg;
        rneg_next   = rneg_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next    = funct3[1:0];
                    count_next = '0;
                    neg_next   = a_neg ^ b_neg;
                    rneg_next  = a_neg;
                    hi_next    = '0;
                    if (fast) begin
                        result_next = fast_res;
                        state_next  = DONE;
                    end else if (is_div) begin
                        lo_next    = mag_a;
                        opnd_next  = mag_b;
                        state_next = DIV;
                    end else begin
                        lo_next    = mag_b;
                        opnd_next  = mag_a;
                        state_next = MUL;
                    end
                end
            end
            MUL, DIV: begin
                hi_next    = iter_hi;
                lo_next    = iter_lo;
                count_next = count_reg + 1'b1;
                if (count_reg == CW'(XLEN-1)) begin
                    result_next = fin_res;
                    state_next  = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next  = IDLE;
            count_next  = '0;
            result_next = result_reg;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opnd_reg   <= '0;
            result_reg <= '0;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            rneg_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            opnd_reg   <= opnd_next;
            result_reg <= result_next;
            op_reg     <= op_next;
            neg_reg    <= neg_next;
            rneg_reg   <= rneg_next;
        end
    end

    assign busy   = (state_reg == MUL) || (state_reg == DIV);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit at XLEN=32 and XLEN=8.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, res32;
    logic [7:0]  a8 = '0, b8 = '0, res8;
    logic        busy32, done32, busy8, done8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rstn(rstn), .start(start32), .funct3(f3),
        .op_a(a32), .op_b(b32), .flush(flush),
        .busy(busy32), .done(done32), .result(res32)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .funct3(f3),
        .op_a(a8), .op_b(b8), .flush(flush),
        .busy(busy8), .done(done8), .result(res8)
    );

    // issue one 32-bit op; cyc = cycle in which done is seen (1 = cycle after accept)
    task automatic run32(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int cyc, output int bcyc);
        @(negedge clk);
        f3 = fn; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        cyc = 1; bcyc = 0;
        while (!done32 && cyc < 100) begin
            if (busy32) bcyc++;
            @(posedge clk); #1;
            cyc++;
        end
        r = res32;
        $display("xlen32 funct3=%b a=%h b=%h result=%h cycles=%0d", fn, a, b, r, cyc);
        @(posedge clk); #1;
    endtask

    task automatic run8(input logic [2:0] fn, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output int cyc);
        @(negedge clk);
        f3 = fn; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        r = res8;
        $display("xlen8 funct3=%b a=%h b=%h result=%h cycles=%0d", fn, a, b, r, cyc);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset32 busy=%b done=%b result=%h required 0/0/0", busy32, done32, res32);
        end
        vectors++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'h0) begin
            miscompares++;
            $display("FAIL reset8 busy=%b done=%b result=%h required 0/0/0", busy8, done8, res8);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_mul;
        logic [31:0] r; int c, b;
        run32(3'b000, 32'd7, 32'hFFFFFFFD, r, c, b);
        vectors++;
        if (r !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mul_7x-3 result=%h required ffffffeb", r); end
        vectors++;
        if (c !== 33) begin miscompares++; $display("FAIL mul_latency got=%0d required 33", c); end
        vectors++;
        if (b !== 32) begin miscompares++; $display("FAIL mul_busy_cycles got=%0d required 32", b); end
    endtask

    task automatic test_mulh;
        logic [31:0] r; int c, b;
        run32(3'b001, 32'h80000000, 32'h80000000, r, c, b);
        vectors++;
        if (r !== 32'h40000000) begin miscompares++; $display("FAIL mulh result=%h required 40000000", r); end
        run32(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, c, b);
        vectors++;
        if (r !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL mulhu result=%h required fffffffe", r); end
        run32(3'b010, 32'hFFFFFFFF, 32'd2, r, c, b);
        vectors++;
        if (r !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mulhsu result=%h required ffffffff", r); end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (res32 !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL result_hold result=%h required ffffffff", res32); end
    endtask

    task automatic test_div;
        logic [31:0] r; int c, b;
        run32(3'b100, 32'hFFFFFFF9, 32'd2, r, c, b);
        vectors++;
        if (r !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_-7/2 result=%h required fffffffd", r); end
        vectors++;
        if (c !== 33) begin miscompares++; $display("FAIL div_latency got=%0d required 33", c); end
        run32(3'b110, 32'hFFFFFFF9, 32'd2, r, c, b);
        vectors++;
        if (r !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL rem_-7/2 result=%h required ffffffff", r); end
        run32(3'b101, 32'd100, 32'd7, r, c, b);
        vectors++;
        if (r !== 32'd14) begin miscompares++; $display("FAIL divu_100/7 result=%h required 0000000e", r); end
        run32(3'b111, 32'd100, 32'd7, r, c, b);
        vectors++;
        if (r !== 32'd2) begin miscompares++; $display("FAIL remu_100/7 result=%h required 00000002", r); end
    endtask

    task automatic test_corner;
        logic [2:0]  fv [5] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100};
        logic [31:0] av [5] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5};
        logic [31:0] bv [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] ev [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF};
        logic [31:0] r; int c, b;
        for (int i = 0; i < 5; i++) begin
            run32(fv[i], av[i], bv[i], r, c, b);
            vectors++;
            if (r !== ev[i]) begin miscompares++; $display("FAIL corner%0d result=%h required %h", i, r, ev[i]); end
            vectors++;
            if (c !== 1) begin miscompares++; $display("FAIL corner%0d_latency got=%0d required 1", i, c); end
        end
    endtask

    task automatic test_flush;
        logic [31:0] prev; bit seen;
        prev = res32;
        @(negedge clk);
        f3 = 3'b100; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (busy32 !== 1'b1) begin miscompares++; $display("FAIL flush_prebusy busy=%b required 1", busy32); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++;
        if (busy32 !== 1'b0 || done32 !== 1'b0) begin
            miscompares++; $display("FAIL flush_idle busy=%b done=%b required 0/0", busy32, done32);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done32) seen = 1'b1; end
        vectors++;
        if (seen !== 1'b0 || res32 !== prev) begin
            miscompares++; $display("FAIL flush_nodone done_seen=%b result=%h required 0/%h", seen, res32, prev);
        end
        $display("xlen32 flushed div at iteration 10");
        @(negedge clk);
        f3 = 3'b000; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; flush = 1'b0;
        vectors++;
        if (busy32 !== 1'b0) begin miscompares++; $display("FAIL start_flush busy=%b required 0", busy32); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done32) seen = 1'b1; end
        vectors++;
        if (seen !== 1'b0 || res32 !== prev) begin
            miscompares++; $display("FAIL start_flush_nodone done_seen=%b result=%h required 0/%h", seen, res32, prev);
        end
        $display("xlen32 start with flush dropped");
    endtask

    task automatic test_start_busy;
        int c;
        @(negedge clk);
        f3 = 3'b000; a32 = 32'd6; b32 = 32'd7; start32 = 1'b1;
        @(posedge clk); #1;
        a32 = 32'd100; b32 = 32'd100; f3 = 3'b011;
        c = 1;
        while (!done32 && c < 100) begin @(posedge clk); #1; c++; end
        start32 = 1'b0;
        $display("xlen32 mul 6x7 with start held high result=%h cycles=%0d", res32, c);
        vectors++;
        if (res32 !== 32'd42 || c !== 33) begin
            miscompares++; $display("FAIL start_busy result=%h cycles=%0d required 0000002a/33", res32, c);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy32 !== 1'b0 || done32 !== 1'b0) begin
            miscompares++; $display("FAIL start_in_done busy=%b done=%b required 0/0", busy32, done32);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        f3 = 3'b000; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        vectors++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'h0) begin
            miscompares++; $display("FAIL reset_mid busy=%b done=%b result=%h required 0/0/0", busy32, done32, res32);
        end
        $display("xlen32 async reset mid-mul");
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_xlen8;
        logic [2:0] fv [11] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                                3'b101, 3'b111, 3'b101, 3'b110, 3'b100};
        logic [7:0] av [11] = '{8'h07, 8'h80, 8'hFF, 8'hFF, 8'hF9, 8'hF9,
                                8'h64, 8'h64, 8'h05, 8'h05, 8'h80};
        logic [7:0] bv [11] = '{8'hFD, 8'h80, 8'hFF, 8'h02, 8'h02, 8'h02,
                                8'h07, 8'h07, 8'h00, 8'h00, 8'hFF};
        logic [7:0] ev [11] = '{8'hEB, 8'h40, 8'hFE, 8'hFF, 8'hFD, 8'hFF,
                                8'h0E, 8'h02, 8'hFF, 8'h05, 8'h80};
        int         lv [11] = '{9, 9, 9, 9, 9, 9, 9, 9, 1, 1, 1};
        logic [7:0] r; int c;
        for (int i = 0; i < 11; i++) begin
            run8(fv[i], av[i], bv[i], r, c);
            vectors++;
            if (r !== ev[i] || c !== lv[i]) begin
                miscompares++;
                $display("FAIL xlen8_vec%0d result=%h cycles=%0d required %h/%0d", i, r, c, ev[i], lv[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_mulh;
        test_div;
        test_corner;
        test_flush;
        test_start_busy;
        test_reset_mid;
        test_xlen8;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
